// File: rtl/vec_issue_ctrl_pkg.sv
// rtl/vec_issue_ctrl_pkg.sv - shared constants and types for the vector issue controller
//
// Purpose: vector funct codes, ALU operand-select encodings, controller state
// enum and default geometry (lanes per beat, beats per instruction).
// Ports: none (package).

package vec_issue_ctrl_pkg;

  localparam int VIC_NUM_LANES = 8;
  localparam int VIC_MAX_BEATS = 4;

  typedef enum logic [5:0] {
    F_ADD_V = 6'b110000,
    F_SUB_V = 6'b110001,
    F_AND_V = 6'b110010,
    F_OR_V  = 6'b110011,
    F_XOR_V = 6'b110100,
    F_MUL_V = 6'b110101
  } vfunct_e;

  // ALU src2 select: scalar broadcast, vector register, or force-zero.
  localparam logic [1:0] ALUOP_VS   = 2'b00;
  localparam logic [1:0] ALUOP_VV   = 2'b10;
  localparam logic [1:0] ALUOP_ZERO = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL1 = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  function automatic logic funct_is_legal(input logic [5:0] f);
    return (f == F_ADD_V) || (f == F_SUB_V) || (f == F_AND_V) ||
           (f == F_OR_V)  || (f == F_XOR_V) || (f == F_MUL_V);
  endfunction

endpackage

// File: rtl/vec_issue_ctrl.sv
// rtl/vec_issue_ctrl.sv - beat-sequencing issue controller for a vector ALU
//
// Purpose: accepts one vector instruction at a time, steps it through
// 1..MAX_BEATS beats, drives ALU funct/operand select, register-file read rows
// and the write-back row for each beat. MUL_V spends two cycles per beat.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       instruction handshake
//   req_funct, req_vd, req_vs1, req_vs2, req_beats, req_scalar  instruction
//   flush                     abort current instruction, back to IDLE
//   alu_funct, alu_op         vector ALU control
//   rd_addr1, rd_addr2        register-file read rows {vreg, beat}
//   wb_en, wb_addr            register-file write of lane results
//   busy, done, err           status; done/err are single-cycle pulses

module vec_issue_ctrl
  import vec_issue_ctrl_pkg::*;
#(
  parameter int NUM_LANES = VIC_NUM_LANES,
  parameter int MAX_BEATS = VIC_MAX_BEATS,
  parameter int RF_AW     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_funct,
  input  logic [2:0]       req_vd,
  input  logic [2:0]       req_vs1,
  input  logic [2:0]       req_vs2,
  input  logic [2:0]       req_beats,
  input  logic             req_scalar,
  input  logic             flush,
  output logic [5:0]       alu_funct,
  output logic [1:0]       alu_op,
  output logic [RF_AW-1:0] rd_addr1,
  output logic [RF_AW-1:0] rd_addr2,
  output logic             wb_en,
  output logic [RF_AW-1:0] wb_addr,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  // Row address is {vreg, beat}; beat count must fit the 3-bit request field.
  if (NUM_LANES < 1 || MAX_BEATS < 1 || MAX_BEATS > 7 || RF_AW != 3 + BEAT_W) begin : g_bad_params
    $error("vec_issue_ctrl: inconsistent NUM_LANES/MAX_BEATS/RF_AW");
  end

  state_e            state_q;
  logic [BEAT_W-1:0] beat_q;
  logic [5:0]        funct_q;
  logic [2:0]        vd_q, vs1_q, vs2_q;
  logic [2:0]        beats_q;
  logic              scalar_q;

  logic req_legal;
  logic is_mul;
  logic last_beat;
  logic active;
  logic kill;

  assign req_legal = funct_is_legal(req_funct) && (req_beats != 3'd0) &&
                     (int'(req_beats) <= MAX_BEATS);
  assign is_mul    = (funct_q == F_MUL_V);
  assign last_beat = (3'(beat_q) == beats_q - 3'd1);
  assign active    = (state_q == S_EXEC) || (state_q == S_MUL1);
  // Flush (and reset) cancel any write/pulse in the cycle they are seen.
  assign kill      = flush || rst;

  assign req_ready = (state_q == S_IDLE) && !kill;
  assign busy      = (state_q != S_IDLE);
  assign alu_funct = active ? funct_q : 6'd0;
  assign alu_op    = !active ? ALUOP_ZERO : (scalar_q ? ALUOP_VS : ALUOP_VV);
  assign rd_addr1  = active ? RF_AW'({vs1_q, beat_q}) : '0;
  assign rd_addr2  = active ? RF_AW'({vs2_q, beat_q}) : '0;
  assign wb_addr   = active ? RF_AW'({vd_q, beat_q}) : '0;
  // MUL_V writes only from MUL1, giving the multiplier a two-cycle path.
  assign wb_en     = !kill && ((state_q == S_MUL1) || (state_q == S_EXEC && !is_mul));
  assign done      = wb_en && last_beat;
  assign err       = !kill && (state_q == S_ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      funct_q  <= '0;
      vd_q     <= '0;
      vs1_q    <= '0;
      vs2_q    <= '0;
      beats_q  <= '0;
      scalar_q <= 1'b0;
    end else if (flush) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            funct_q  <= req_funct;
            vd_q     <= req_vd;
            vs1_q    <= req_vs1;
            vs2_q    <= req_vs2;
            beats_q  <= req_beats;
            scalar_q <= req_scalar;
            beat_q   <= '0;
            state_q  <= req_legal ? S_EXEC : S_ERR;
          end
        end
        S_EXEC, S_MUL1: begin
          if (state_q == S_EXEC && is_mul) begin
            state_q <= S_MUL1;
          end else if (last_beat) begin
            beat_q  <= '0;
            state_q <= S_IDLE;
          end else begin
            beat_q  <= beat_q + BEAT_W'(1);
            state_q <= S_EXEC;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// tb/tb_vec_issue_ctrl.sv - self-checking bench for vec_issue_ctrl

module tb_vec_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst, req_valid, req_ready, req_scalar, flush;
  logic [5:0] req_funct, alu_funct;
  logic [2:0] req_vd, req_vs1, req_vs2, req_beats;
  logic [1:0] alu_op;
  logic [4:0] rd_addr1, rd_addr2, wb_addr;
  logic       wb_en, busy, done, err;

  always #5 clk = ~clk;

  vec_issue_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_funct(req_funct), .req_vd(req_vd), .req_vs1(req_vs1), .req_vs2(req_vs2),
    .req_beats(req_beats), .req_scalar(req_scalar), .flush(flush),
    .alu_funct(alu_funct), .alu_op(alu_op), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .wb_en(wb_en), .wb_addr(wb_addr), .busy(busy), .done(done), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  // One entry per expected active cycle of the current instruction.
  typedef struct packed {
    logic       wb;
    logic [1:0] beat;
    logic       last;
  } rec_t;

  rec_t       sched[$];
  logic [5:0] m_funct;
  logic [2:0] m_vd, m_vs1, m_vs2;
  logic       m_scalar;
  logic       m_err = 1'b0;

  // {busy, ready, wb_en, done, err, alu_op, alu_funct, rd1, rd2, wb_addr}
  logic [27:0] exp_vec, obs_vec;

  int         wr_cyc[$];
  logic [4:0] wr_addr[$];
  int         done_cyc[$];
  int         err_cyc[$];

  function automatic logic legal(input logic [5:0] f, input logic [2:0] b);
    return (f inside {6'b110000, 6'b110001, 6'b110010, 6'b110011, 6'b110100, 6'b110101})
           && (b >= 3'd1) && (b <= 3'd4);
  endfunction

  function automatic logic [27:0] model_out(input logic fl, input logic rs);
    logic bz, rdy, wb, dn, er;
    logic [1:0] op;
    logic [5:0] fn;
    logic [4:0] a1, a2, aw;
    rec_t r;
    bz = 0; rdy = 0; wb = 0; dn = 0; er = 0;
    op = 2'b11; fn = 6'd0; a1 = 5'd0; a2 = 5'd0; aw = 5'd0;
    if (sched.size() > 0) begin
      r  = sched[0];
      bz = 1;
      fn = m_funct;
      op = m_scalar ? 2'b00 : 2'b10;
      a1 = {m_vs1, r.beat};
      a2 = {m_vs2, r.beat};
      aw = {m_vd, r.beat};
      wb = r.wb && !fl && !rs;
      dn = wb && r.last;
    end else if (m_err) begin
      bz = 1;
      er = !fl && !rs;
    end else begin
      rdy = !fl && !rs;
    end
    return {bz, rdy, wb, dn, er, op, fn, a1, a2, aw};
  endfunction

  task automatic model_update(input logic v, input logic [5:0] f, input logic [2:0] vd,
                              input logic [2:0] vs1, input logic [2:0] vs2,
                              input logic [2:0] b, input logic sc, input logic fl,
                              input logic rs);
    rec_t r;
    if (rs || fl) begin
      sched.delete();
      m_err = 1'b0;
    end else if (sched.size() > 0) begin
      void'(sched.pop_front());
    end else if (m_err) begin
      m_err = 1'b0;
    end else if (v) begin
      m_funct = f; m_vd = vd; m_vs1 = vs1; m_vs2 = vs2; m_scalar = sc;
      if (legal(f, b)) begin
        for (int bb = 0; bb < int'(b); bb++) begin
          if (f == 6'b110101) begin
            r = '{wb: 1'b0, beat: 2'(bb), last: 1'b0};
            sched.push_back(r);
          end
          r = '{wb: 1'b1, beat: 2'(bb), last: (bb == int'(b) - 1)};
          sched.push_back(r);
        end
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic begin_test();
    cyc = 0;
    wr_cyc.delete(); wr_addr.delete(); done_cyc.delete(); err_cyc.delete();
  endtask

  // Drive one cycle, capture expected/observed outputs, advance model and DUT.
  task automatic step(input logic v, input logic [5:0] f, input logic [2:0] vd,
                      input logic [2:0] vs1, input logic [2:0] vs2, input logic [2:0] b,
                      input logic sc, input logic fl, input logic rs);
    req_valid = v; req_funct = f; req_vd = vd; req_vs1 = vs1; req_vs2 = vs2;
    req_beats = b; req_scalar = sc; flush = fl; rst = rs;
    #1;
    exp_vec = model_out(fl, rs);
    obs_vec = {busy, req_ready, wb_en, done, err, alu_op, alu_funct, rd_addr1, rd_addr2, wb_addr};
    if (wb_en === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(wb_addr);
    end
    if (done === 1'b1) done_cyc.push_back(cyc);
    if (err === 1'b1) err_cyc.push_back(cyc);
    @(posedge clk);
    model_update(v, f, vd, vs1, vs2, b, sc, fl, rs);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    begin_test();
    step(1'b0, 6'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({wb_en, done, err} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_pulses got %b want 000", {wb_en, done, err});
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 6'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, (i == 0));
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++;
        $display("FAIL reset_cycle%0d got %h want %h", i, obs_vec, exp_vec);
      end
    end
    n_cmp++;
    if (obs_vec !== {1'b0, 1'b1, 3'b000, 2'b11, 6'd0, 15'd0}) begin
      n_bad++;
      $display("FAIL reset_idle_outputs got %h want %h", obs_vec,
               {1'b0, 1'b1, 3'b000, 2'b11, 6'd0, 15'd0});
    end
  endtask

  task automatic test_add();
    begin_test();
    for (int i = 0; i < 7; i++) begin
      step((i == 0), 6'b110000, 3'd2, 3'd0, 3'd1, 3'd4, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++;
        $display("FAIL add_cycle%0d got %h want %h", i, obs_vec, exp_vec);
      end
    end
    n_cmp++;
    if (wr_cyc.size() != 4 || wr_cyc[0] != 1 || wr_cyc[3] != 4 || wr_addr[0] != 5'd8 ||
        wr_addr[1] != 5'd9 || wr_addr[2] != 5'd10 || wr_addr[3] != 5'd11) begin
      n_bad++;
      $display("FAIL add_writes got n=%0d first_addr=%0d want n=4 addrs 8..11 cycles 1..4",
               wr_cyc.size(), (wr_addr.size() > 0) ? wr_addr[0] : 5'd0);
    end
    n_cmp++;
    if (done_cyc.size() != 1 || done_cyc[0] != 4) begin
      n_bad++;
      $display("FAIL add_done got n=%0d want one pulse at cycle 4", done_cyc.size());
    end
  endtask

  task automatic test_mul();
    logic [27:0] obs1;
    begin_test();
    obs1 = '0;
    for (int i = 0; i < 6; i++) begin
      step((i == 0), 6'b110101, 3'd5, 3'd6, 3'd7, 3'd2, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++;
        $display("FAIL mul_cycle%0d got %h want %h", i, obs_vec, exp_vec);
      end
      if (i == 1) obs1 = obs_vec;
      if (i == 2) begin
        n_cmp++;
        if (obs1[22:21] !== 2'b00 || obs1[14:0] !== {5'd24, 5'd28, 5'd20} ||
            obs_vec[14:0] !== {5'd24, 5'd28, 5'd20}) begin
          n_bad++;
          $display("FAIL mul_hold got op=%b a=%h/%h want op=00 a=%h",
                   obs1[22:21], obs1[14:0], obs_vec[14:0], {5'd24, 5'd28, 5'd20});
        end
      end
    end
    n_cmp++;
    if (wr_cyc.size() != 2 || wr_cyc[0] != 2 || wr_cyc[1] != 4 ||
        wr_addr[0] != 5'd20 || wr_addr[1] != 5'd21) begin
      n_bad++;
      $display("FAIL mul_writes got n=%0d want cycles 2,4 addrs 20,21", wr_cyc.size());
    end
    n_cmp++;
    if (done_cyc.size() != 1 || done_cyc[0] != 4) begin
      n_bad++;
      $display("FAIL mul_done got n=%0d want one pulse at cycle 4", done_cyc.size());
    end
  endtask

  task automatic test_illegal();
    logic [5:0] fs [3] = '{6'b111111, 6'b110000, 6'b110010};
    logic [2:0] bs [3] = '{3'd1, 3'd0, 3'd5};
    for (int k = 0; k < 3; k++) begin
      begin_test();
      for (int i = 0; i < 3; i++) begin
        step((i == 0), fs[k], 3'd1, 3'd1, 3'd1, bs[k], 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs_vec !== exp_vec) begin
          n_bad++;
          $display("FAIL illegal%0d_cycle%0d got %h want %h", k, i, obs_vec, exp_vec);
        end
      end
      n_cmp++;
      if (err_cyc.size() != 1 || err_cyc[0] != 1 || wr_cyc.size() != 0 || req_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL illegal%0d got errs=%0d writes=%0d ready=%b want 1/0/1",
                 k, err_cyc.size(), wr_cyc.size(), req_ready);
      end
    end
  endtask

  task automatic test_flush();
    begin_test();
    for (int i = 0; i < 5; i++) begin
      step((i == 0), 6'b110100, 3'd1, 3'd2, 3'd3, 3'd4, 1'b0, (i == 2), 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++;
        $display("FAIL flush_cycle%0d got %h want %h", i, obs_vec, exp_vec);
      end
      if (i == 3) begin
        n_cmp++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
          n_bad++;
          $display("FAIL flush_idle got busy=%b ready=%b want 0/1", busy, req_ready);
        end
      end
    end
    n_cmp++;
    if (wr_cyc.size() != 1 || wr_addr[0] != 5'd4 || done_cyc.size() != 0) begin
      n_bad++;
      $display("FAIL flush_writes got writes=%0d dones=%0d want 1/0", wr_cyc.size(), done_cyc.size());
    end
  endtask

  task automatic test_rst_mul1();
    begin_test();
    for (int i = 0; i < 4; i++) begin
      step((i == 0), 6'b110101, 3'd3, 3'd4, 3'd5, 3'd3, 1'b0, 1'b0, (i == 2));
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++;
        $display("FAIL rstmul_cycle%0d got %h want %h", i, obs_vec, exp_vec);
      end
    end
    n_cmp++;
    if (wr_cyc.size() != 0 || obs_vec !== {1'b0, 1'b1, 3'b000, 2'b11, 6'd0, 15'd0}) begin
      n_bad++;
      $display("FAIL rstmul_after got writes=%0d vec=%h want 0 and %h", wr_cyc.size(),
               obs_vec, {1'b0, 1'b1, 3'b000, 2'b11, 6'd0, 15'd0});
    end
  endtask

  task automatic test_back_to_back();
    int sent;
    begin_test();
    sent = 0;
    for (int i = 0; i < 9; i++) begin
      if (sent == 0)
        step(1'b1, 6'b110001, 3'd0, 3'd1, 3'd2, 3'd2, 1'b0, 1'b0, 1'b0);
      else if (sent == 1)
        step(1'b1, 6'b110001, 3'd7, 3'd3, 3'd4, 3'd3, 1'b0, 1'b0, 1'b0);
      else
        step(1'b0, 6'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++;
        $display("FAIL b2b_cycle%0d got %h want %h", i, obs_vec, exp_vec);
      end
      if (sent < 2 && obs_vec[26] === 1'b1) sent++;
    end
    n_cmp++;
    if (wr_cyc.size() != 5 || wr_cyc[0] != 1 || wr_cyc[1] != 2 || wr_cyc[2] != 4 ||
        wr_cyc[4] != 6 || wr_addr[0] != 5'd0 || wr_addr[1] != 5'd1 ||
        wr_addr[2] != 5'd28 || wr_addr[3] != 5'd29 || wr_addr[4] != 5'd30) begin
      n_bad++;
      $display("FAIL b2b_writes got n=%0d want cycles 1,2,4,5,6 addrs 0,1,28,29,30", wr_cyc.size());
    end
    n_cmp++;
    if (done_cyc.size() != 2 || done_cyc[0] != 2 || done_cyc[1] != 6) begin
      n_bad++;
      $display("FAIL b2b_done got n=%0d want pulses at 2 and 6", done_cyc.size());
    end
  endtask

  task automatic test_random();
    logic [5:0] f;
    begin_test();
    for (int i = 0; i < 400; i++) begin
      f = ($urandom_range(0, 99) < 85) ? 6'(6'h30 + $urandom_range(0, 5)) : 6'($urandom);
      step(($urandom_range(0, 3) != 0), f, 3'($urandom), 3'($urandom), 3'($urandom),
           3'($urandom_range(0, 5)), 1'($urandom), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 99) == 0));
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++;
        $display("FAIL random_cycle%0d got %h want %h", i, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_funct = '0; req_vd = '0; req_vs1 = '0;
    req_vs2 = '0; req_beats = '0; req_scalar = 1'b0; flush = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_mul();
    test_illegal();
    test_flush();
    test_rst_mul1();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
